bus_arbiter: RTL and testbench

Single-port memory arbiter for the MIPS core. It shares one unified memory bus between instruction fetch (the IF `romCe`/`instAddr` port) and data access (the MEM `memCe`/`memWr`/`memAddr`/`wtData` port). It sequences each access through a handshake with the bus slave and holds the pipeline with `stall` until every request issued this cycle has completed. A watchdog converts a missing slave acknowledge into a bus-error pulse for the exception logic.

---
 rtl/mips_bus_pkg.sv | 23 ++
 rtl/bus_arbiter_if.sv | 39 +++
 rtl/bus_watchdog.sv | 40 ++++
 rtl/bus_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS unified-memory bus arbiter.
// Provides the FSM state encoding, bus and watchdog widths, the default
// watchdog limit and the latched bus request payload.
package mips_bus_pkg;

   localparam int unsigned BUS_W       = 32;
   localparam int unsigned WDOG_W      = 8;
   localparam int unsigned TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_INST = 2'd2
   } arb_state_e;

   // Request held on the bus for the whole duration of one access
   typedef struct packed {
      logic             wr;
      logic [BUS_W-1:0] addr;
      logic [BUS_W-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the pipeline-side and bus-side signals of the memory arbiter.
// master : arbiter view (takes IF/MEM requests and slave responses, drives bus)
// slave  : environment view (pipeline stages plus the memory slave)
interface bus_arbiter_if
   import mips_bus_pkg::*;
   ;

   logic             romCe;
   logic [BUS_W-1:0] instAddr;
   logic [BUS_W-1:0] instruction;
   logic             instRdy;
   logic             memCe;
   logic             memWr;
   logic [BUS_W-1:0] memAddr;
   logic [BUS_W-1:0] wtData;
   logic [BUS_W-1:0] rdData;
   logic             memRdy;
   logic             stall;
   logic             busErr;
   logic             busCe;
   logic             busWr;
   logic [BUS_W-1:0] busAddr;
   logic [BUS_W-1:0] busWData;
   logic [BUS_W-1:0] busRData;
   logic             busAck;

   modport master (
      input  romCe, instAddr, memCe, memWr, memAddr, wtData, busRData, busAck,
      output instruction, instRdy, rdData, memRdy, stall, busErr,
             busCe, busWr, busAddr, busWData
   );

   modport slave (
      output romCe, instAddr, memCe, memWr, memAddr, wtData, busRData, busAck,
      input  instruction, instRdy, rdData, memRdy, stall, busErr,
             busCe, busWr, busAddr, busWData
   );

endinterface

// File: rtl/bus_watchdog.sv
// Busy-cycle counter that flags an access whose acknowledge never arrives.
// clk, rst     : clock, async active-high reset
// clear_i      : hold the count at zero (arbiter idle)
// busy_i       : an access is outstanding on the bus
// ack_i        : slave acknowledge this cycle
// expire_c_o   : terminal count reached without ack (combinational)
module bus_watchdog
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic busy_i,
   input  logic ack_i,
   output logic expire_c_o
);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   // Count busy cycles that end without an acknowledge
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (busy_i && !ack_i) begin
         cnt_d = cnt_q + WDOG_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // An ack in the terminal cycle wins over the abort
   assign expire_c_o = busy_i && !ack_i && (cnt_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Single-port memory arbiter sharing one bus between instruction fetch and
// data access. Data has priority; the pipeline is held with stall until every
// request raised in the current step has completed or been aborted.
// clk, rst : clock, async active-high reset
// bus_io   : pipeline request/response signals and memory-bus handshake
module bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   bus_arbiter_if.master  bus_io
);

   arb_state_e       state_q, state_d;
   bus_req_t         req_q, req_d;
   logic             bus_ce_q, bus_ce_d;
   logic             bus_err_q, bus_err_d;
   logic             done_data_q, done_data_d;
   logic             done_inst_q, done_inst_d;
   logic [BUS_W-1:0] instr_q, instr_d;
   logic [BUS_W-1:0] rdata_q, rdata_d;
   logic             pend_data, pend_inst, stall_c;
   logic             expire_c;

   // A side is pending until its done flag is set for this pipeline step
   assign pend_data = bus_io.memCe & ~done_data_q;
   assign pend_inst = bus_io.romCe & ~done_inst_q;
   assign stall_c   = pend_data | pend_inst;

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (state_q == ST_IDLE),
      .busy_i     (bus_ce_q),
      .ack_i      (bus_io.busAck),
      .expire_c_o (expire_c)
   );

   // Next-state, grant and completion logic
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      bus_ce_d    = bus_ce_q;
      bus_err_d   = 1'b0;
      done_data_d = stall_c ? done_data_q : 1'b0;
      done_inst_d = stall_c ? done_inst_q : 1'b0;
      instr_d     = instr_q;
      rdata_d     = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pend_data) begin
               req_d    = '{wr: bus_io.memWr, addr: bus_io.memAddr, wdata: bus_io.wtData};
               bus_ce_d = 1'b1;
               state_d  = ST_DATA;
            end else if (pend_inst) begin
               req_d.wr   = 1'b0;
               req_d.addr = bus_io.instAddr;
               bus_ce_d   = 1'b1;
               state_d    = ST_INST;
            end
         end
         ST_DATA: begin
            if (bus_io.busAck || expire_c) begin
               done_data_d = 1'b1;
               bus_err_d   = !bus_io.busAck;
               // A store never touches the load-data register
               if (!req_q.wr) rdata_d = bus_io.busAck ? bus_io.busRData : '0;
               req_d.wr    = 1'b0;
               bus_ce_d    = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_INST: begin
            if (bus_io.busAck || expire_c) begin
               done_inst_d = 1'b1;
               bus_err_d   = !bus_io.busAck;
               instr_d     = bus_io.busAck ? bus_io.busRData : '0;
               bus_ce_d    = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            bus_ce_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         bus_ce_q    <= 1'b0;
         bus_err_q   <= 1'b0;
         done_data_q <= 1'b0;
         done_inst_q <= 1'b0;
         instr_q     <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         bus_ce_q    <= bus_ce_d;
         bus_err_q   <= bus_err_d;
         done_data_q <= done_data_d;
         done_inst_q <= done_inst_d;
         instr_q     <= instr_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus_io.busCe       = bus_ce_q;
   assign bus_io.busWr       = req_q.wr;
   assign bus_io.busAddr     = req_q.addr;
   assign bus_io.busWData    = req_q.wdata;
   assign bus_io.busErr      = bus_err_q;
   assign bus_io.memRdy      = done_data_q;
   assign bus_io.instRdy     = done_inst_q;
   assign bus_io.rdData      = rdata_q;
   assign bus_io.instruction = instr_q;
   assign bus_io.stall       = stall_c;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Each pipeline step is described by its
// requests and the slave latency of each access; a schedule model derives the
// expected bus windows, done cycles and stall fall from those latencies.
module tb_bus_arbiter;
   import mips_bus_pkg::*;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_arbiter_if bus_if ();

   bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus_if.master)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_rd   = 32'h0;
   logic [31:0] exp_inst = 32'h0;
   int dut_fall, dut_falls, dut_err_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (time %0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (time %0t)", name, act, exp, $time);
      end
   endtask

   // One pipeline step. Called at posedge+1; that cycle is step cycle 0.
   task automatic run_step(
      input logic d_ce, input logic d_wr, input logic [31:0] d_addr,
      input logic [31:0] d_wdata, input int d_wait, input logic [31:0] d_word,
      input logic i_ce, input logic [31:0] i_addr, input int i_wait,
      input logic [31:0] i_word);
      int ld, li, s_i, e_i, e_end, seg, cnt, w;
      bit err_d, err_i, prev_ce, prev_stall, busy_d, busy_i;
      logic [31:0] rd_new, inst_new, word;

      // Schedule: an access is busy for min(wait+1, TO) cycles, then IDLE
      ld    = d_ce ? ((d_wait + 1 > TO) ? TO : d_wait + 1) : 0;
      err_d = d_ce && (d_wait + 1 > TO);
      li    = i_ce ? ((i_wait + 1 > TO) ? TO : i_wait + 1) : 0;
      err_i = i_ce && (i_wait + 1 > TO);
      s_i   = d_ce ? ld + 2 : 1;
      e_i   = s_i + li - 1;
      e_end = i_ce ? e_i + 1 : (d_ce ? ld + 1 : 0);
      rd_new   = (d_ce && !d_wr) ? (err_d ? 32'h0 : d_word) : exp_rd;
      inst_new = i_ce ? (err_i ? 32'h0 : i_word) : exp_inst;

      bus_if.memCe    = d_ce;
      bus_if.memWr    = d_wr;
      bus_if.memAddr  = d_addr;
      bus_if.wtData   = d_wdata;
      bus_if.romCe    = i_ce;
      bus_if.instAddr = i_addr;

      seg = -1; cnt = 0; prev_ce = 1'b0; prev_stall = 1'b1;
      dut_fall = -1; dut_falls = 0; dut_err_t = -1;

      for (int t = 0; t <= e_end; t++) begin
         // Slave responder: ack after the programmed number of wait cycles
         if (bus_if.busCe) begin
            if (!prev_ce) begin seg++; cnt = 0; end
            else cnt++;
         end
         prev_ce = bus_if.busCe;
         if (bus_if.busCe) begin
            w    = (d_ce && seg == 0) ? d_wait : i_wait;
            word = (d_ce && seg == 0) ? d_word : i_word;
            bus_if.busAck   = (cnt == w);
            bus_if.busRData = (cnt == w) ? word : 32'hBAD0_0000;
         end else begin
            bus_if.busAck   = 1'b0;
            bus_if.busRData = 32'h0;
         end
         #1;
         busy_d = d_ce && t >= 1 && t <= ld;
         busy_i = i_ce && t >= s_i && t <= e_i;
         chk1("busCe", bus_if.busCe, busy_d || busy_i);
         if (busy_d) begin
            chk("busAddr data", bus_if.busAddr, d_addr);
            chk1("busWr data", bus_if.busWr, d_wr);
            if (d_wr) chk("busWData", bus_if.busWData, d_wdata);
         end
         if (busy_i) begin
            chk("busAddr fetch", bus_if.busAddr, i_addr);
            chk1("busWr fetch", bus_if.busWr, 1'b0);
         end
         chk1("stall", bus_if.stall, t < e_end);
         chk1("memRdy", bus_if.memRdy, d_ce && t > ld);
         chk1("instRdy", bus_if.instRdy, i_ce && t > e_i);
         chk1("busErr", bus_if.busErr, (err_d && t == ld + 1) || (err_i && t == e_i + 1));
         chk("rdData", bus_if.rdData, (d_ce && t > ld) ? rd_new : exp_rd);
         chk("instruction", bus_if.instruction, (i_ce && t > e_i) ? inst_new : exp_inst);
         if (!bus_if.stall && prev_stall) begin
            dut_falls++;
            if (dut_fall < 0) dut_fall = t;
         end
         prev_stall = bus_if.stall;
         if (bus_if.busErr) dut_err_t = t;
         @(posedge clk); #1;
      end

      bus_if.memCe  = 1'b0;
      bus_if.romCe  = 1'b0;
      bus_if.busAck = 1'b0;
      exp_rd   = rd_new;
      exp_inst = inst_new;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1;
      bus_if.romCe = 1'b0; bus_if.instAddr = 32'h0;
      bus_if.memCe = 1'b0; bus_if.memWr = 1'b0;
      bus_if.memAddr = 32'h0; bus_if.wtData = 32'h0;
      bus_if.busAck = 1'b0; bus_if.busRData = 32'h0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk1("rst busCe", bus_if.busCe, 1'b0);
      chk1("rst busWr", bus_if.busWr, 1'b0);
      chk1("rst busErr", bus_if.busErr, 1'b0);
      chk1("rst memRdy", bus_if.memRdy, 1'b0);
      chk1("rst instRdy", bus_if.instRdy, 1'b0);
      chk1("rst stall", bus_if.stall, 1'b0);
      chk("rst busAddr", bus_if.busAddr, 32'h0);
      chk("rst busWData", bus_if.busWData, 32'h0);
      chk("rst rdData", bus_if.rdData, 32'h0);
      chk("rst instruction", bus_if.instruction, 32'h0);
      rst = 1'b0;

      // Idle steps: nothing granted, never stalls
      repeat (3) run_step(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h0, 0, 32'h0);

      // Fetch only, zero-wait slave
      run_step(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h40, 0, 32'h2401_0005);
      chk("fetch stall fall cycle", 32'(dut_fall), 32'd2);
      chk("fetch instruction", bus_if.instruction, 32'h2401_0005);

      // Load + fetch, zero-wait each: stall low in cycle 4
      run_step(1'b1, 1'b0, 32'h80, 32'h0, 0, 32'hA5A5_0001, 1'b1, 32'h3C, 0, 32'h0000_0123);
      chk("ld+fetch zw stall fall", 32'(dut_fall), 32'd4);

      // Load 0x100 + fetch 0x44, three wait cycles each (ack on terminal count)
      run_step(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'h1111_2222, 1'b1, 32'h44, 3, 32'h2402_0007);
      chk("ld+fetch stall fall", 32'(dut_fall), 32'd10);
      chk("ld+fetch stall falls", 32'(dut_falls), 32'd1);
      chk("ld+fetch rdData", bus_if.rdData, 32'h1111_2222);
      chk1("ld+fetch no busErr", dut_err_t < 0, 1'b1);

      // Store leaves rdData alone
      run_step(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 2, 32'h5555_5555, 1'b0, 32'h0, 0, 32'h0);
      chk("store rdData kept", bus_if.rdData, 32'h1111_2222);

      // Load timeout: slave never acks
      run_step(1'b1, 1'b0, 32'h300, 32'h0, 1000, 32'h7777_7777, 1'b0, 32'h0, 0, 32'h0);
      chk("timeout busErr cycle", 32'(dut_err_t), 32'd5);
      chk("timeout rdData", bus_if.rdData, 32'h0);

      // Ack arriving together with terminal count
      run_step(1'b1, 1'b0, 32'h304, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 32'h0, 0, 32'h0);
      chk1("coincident no busErr", dut_err_t < 0, 1'b1);
      chk("coincident rdData", bus_if.rdData, 32'hCAFE_F00D);

      // Fetch timeout zeroes the instruction
      run_step(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h48, 1000, 32'h1234_0000);
      chk("fetch timeout instruction", bus_if.instruction, 32'h0);

      // Reset in the middle of a data access
      bus_if.memCe = 1'b1; bus_if.memWr = 1'b0; bus_if.memAddr = 32'h400;
      bus_if.busAck = 1'b0;
      @(posedge clk); #1;
      chk1("mid busCe granted", bus_if.busCe, 1'b1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk1("mid rst busCe", bus_if.busCe, 1'b0);
      chk1("mid rst memRdy", bus_if.memRdy, 1'b0);
      chk1("mid rst stall", bus_if.stall, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_rd   = 32'h0;
      exp_inst = 32'h0;
      run_step(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'h1234_5678, 1'b0, 32'h0, 0, 32'h0);
      chk("post-reset load", bus_if.rdData, 32'h1234_5678);

      run_step(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h0, 0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
